// File: rtl/text_page_streamer.sv
// Page-organised LCD text RAM with a runtime write port. A start pulse streams one page
// to the LCD driver as HOME_CMD, chars, LINE2_CMD inserted mid-page, and the rest of the chars.
module text_page_streamer #(
    parameter int                    DATA_WIDTH      = 9,
    parameter int                    ADDR_WIDTH      = 6,
    parameter int                    PAGE_ADDR_WIDTH = 5,
    parameter int                    NUM_PAGES       = 4,
    parameter int                    CHARS_PER_PAGE  = 32,
    parameter int                    LINE_LEN        = 16,
    parameter logic [DATA_WIDTH-1:0] HOME_CMD        = 9'h080,
    parameter logic [DATA_WIDTH-1:0] LINE2_CMD       = 9'h0C0,
    parameter string                 INIT_FILE       = ""
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [PAGE_ADDR_WIDTH-1:0] wr_page,
    input  logic [ADDR_WIDTH-1:0]      wr_addr,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       start,
    input  logic [PAGE_ADDR_WIDTH-1:0] page,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    // RAM holds only the pages that exist; the page field is cut to its useful width.
    localparam int PW    = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
    localparam int DEPTH = 1 << (PW + ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0]    LAST_IDX = ADDR_WIDTH'(CHARS_PER_PAGE - 1);
    localparam logic [ADDR_WIDTH-1:0]    L1_IDX   = ADDR_WIDTH'((LINE_LEN > 0) ? LINE_LEN - 1 : 0);
    localparam bit                       HAS_L2   = (LINE_LEN != 0);
    localparam logic [PAGE_ADDR_WIDTH:0] NP       = (PAGE_ADDR_WIDTH + 1)'(NUM_PAGES);
    localparam logic [ADDR_WIDTH:0]      NC       = (ADDR_WIDTH + 1)'(CHARS_PER_PAGE);

    typedef enum logic [2:0] {S_IDLE, S_HOME, S_FETCH, S_EMIT, S_LINE2, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [PW-1:0]         page_q, page_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wr_ok, page_ok;

    assign wr_ok   = wr_en && ({1'b0, wr_page} < NP) && ({1'b0, wr_addr} < NC);
    assign page_ok = ({1'b0, page} < NP);

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[{wr_page[PW-1:0], wr_addr}] <= wr_data;
    end

    // Read-first: a write landing in the FETCH cycle is not seen by this read.
    always_ff @(posedge clk) begin
        if (state_q == S_FETCH)
            rd_data <= mem[{page_q, idx_q}];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            page_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            page_q  <= page_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        page_d    = page_q;
        err_d     = 1'b0;
        out_data  = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (page_ok) begin
                        state_d = S_HOME;
                        idx_d   = '0;
                        page_d  = page[PW-1:0];
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_HOME: begin
                out_data  = HOME_CMD;
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) state_d = S_FETCH;
            end
            S_FETCH: begin
                busy    = 1'b1;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                out_data  = rd_data;
                out_valid = 1'b1;
                busy      = 1'b1;
                out_last  = (idx_q == LAST_IDX);
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = (HAS_L2 && idx_q == L1_IDX) ? S_LINE2 : S_FETCH;
                    end
                end
            end
            S_LINE2: begin
                out_data  = LINE2_CMD;
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) state_d = S_FETCH;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign err = err_q;

endmodule

// File: tb/tb_text_page_streamer.sv
// Directed bench: a scoreboard queue of expected words (data, last, cycle) is built per stream
// and popped on each transfer; a second instance covers LINE_LEN = 0, CHARS_PER_PAGE = 8.
module tb_text_page_streamer;

    logic       clk = 1'b0;
    logic       rst, wr_en, start, out_ready;
    logic [4:0] wr_page, page;
    logic [5:0] wr_addr;
    logic [8:0] wr_data;
    logic [8:0] a_data, b_data;
    logic       a_valid, a_last, a_busy, a_done, a_err;
    logic       b_valid, b_last, b_busy, b_done, b_err;

    always #5 clk = ~clk;

    text_page_streamer dut_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_page(wr_page), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .page(page), .out_data(a_data),
        .out_valid(a_valid), .out_ready(out_ready), .out_last(a_last),
        .busy(a_busy), .done(a_done), .err(a_err)
    );

    text_page_streamer #(.LINE_LEN(0), .CHARS_PER_PAGE(8)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_page(wr_page), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .page(page), .out_data(b_data),
        .out_valid(b_valid), .out_ready(out_ready), .out_last(b_last),
        .busy(b_busy), .done(b_done), .err(b_err)
    );

    typedef struct {
        logic [8:0] data;
        logic       last;
        int         cyc;
    } exp_t;

    int         checks = 0;
    int         errors = 0;
    exp_t       exp_q[$];
    logic [8:0] model[32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        start     = 1'b0;
        wr_en     = 1'b0;
        rst       = 1'b0;
        out_ready = 1'b1;
        page      = 5'd0;
    endtask

    // Single write cycle; the model tracks page 1 only.
    task automatic wr(input int p, input int a, input logic [8:0] v);
        @(posedge clk); #1;
        wr_en   = 1'b1;
        wr_page = 5'(p);
        wr_addr = 6'(a);
        wr_data = v;
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (p == 1 && a < 32) model[a] = v;
    endtask

    // Streams page 1. Optional: ready low over [stall_lo,stall_hi], a write of wr_val to
    // page 1 / wr_idx at cycle wr_cyc, rst high at rst_cyc, a stray start at extra_start.
    task automatic run_stream(input bit use_b, input int ll, input int cpp,
                              input int stall_lo, input int stall_hi,
                              input int wr_cyc, input int wr_idx, input logic [8:0] wr_val,
                              input int rst_cyc, input int extra_start);
        int         rel, c, last_cyc, exp_done;
        bit         stalled, fin, held_v;
        logic [8:0] d, held_d, od;
        logic       held_l, ov, ol, ob, odn;
        exp_t       e;
        stalled  = (stall_lo >= 0);
        fin      = 1'b0;
        held_v   = 1'b0;
        held_d   = '0;
        held_l   = 1'b0;
        last_cyc = 0;
        exp_q.delete();
        exp_q.push_back('{9'h080, 1'b0, stalled ? -1 : 1});
        for (int i = 0; i < cpp; i++) begin
            c = (ll != 0 && i >= ll) ? 2 * i + 4 : 3 + 2 * i;
            d = model[i];
            if (wr_cyc >= 0 && i == wr_idx && wr_cyc < c - 1) d = wr_val;
            exp_q.push_back('{d, (i == cpp - 1), stalled ? -1 : c});
            if (ll != 0 && i == ll - 1) exp_q.push_back('{9'h0C0, 1'b0, stalled ? -1 : 2 * ll + 2});
            last_cyc = c;
        end
        exp_done = last_cyc + 1 + (stalled ? stall_hi - stall_lo + 1 : 0);

        rel = 0;
        while (!fin && rel < 200) begin
            @(posedge clk); #1;
            start     = (rel == 0) || (rel == extra_start);
            page      = (rel == 0) ? 5'd1 : 5'd2;
            out_ready = !(stalled && rel >= stall_lo && rel <= stall_hi);
            wr_en     = (rel == wr_cyc);
            wr_page   = 5'd1;
            wr_addr   = 6'(wr_idx);
            wr_data   = wr_val;
            rst       = (rel == rst_cyc);
            @(negedge clk);
            ov  = use_b ? b_valid : a_valid;
            od  = use_b ? b_data  : a_data;
            ol  = use_b ? b_last  : a_last;
            ob  = use_b ? b_busy  : a_busy;
            odn = use_b ? b_done  : a_done;
            if (rst_cyc >= 0 && rel == rst_cyc + 1) begin
                chk("rst_mid_outputs", {a_data, a_valid, a_last, a_busy, a_done, a_err}, 0);
                exp_q.delete();
                fin = 1'b1;
            end else begin
                if (rel > 0) chk("busy", ob, (rel < exp_done));
                if (extra_start >= 0 && rel == extra_start + 1) chk("err_on_busy_start", a_err, 0);
                if (ov && !out_ready) begin
                    if (held_v) begin
                        chk("stall_hold_data", od, held_d);
                        chk("stall_hold_last", ol, held_l);
                    end else begin
                        held_v = 1'b1;
                        held_d = od;
                        held_l = ol;
                    end
                end
                if (ov && out_ready) begin
                    held_v = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", od, 9'h1FF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word_data", od, e.data);
                        chk("word_last", ol, e.last);
                        if (e.cyc >= 0) chk("word_cycle", rel, e.cyc);
                    end
                end
                if (odn) begin
                    chk("done_cycle", rel, exp_done);
                    chk("words_left", exp_q.size(), 0);
                    fin = 1'b1;
                end
            end
            rel++;
        end
        if (!fin) chk("stream_timeout", rel, 0);
        idle_inputs();
        if (wr_cyc >= 0 && (rst_cyc < 0 || wr_cyc <= rst_cyc)) model[wr_idx] = wr_val;
    endtask

    initial begin
        idle_inputs();
        wr_page = '0;
        wr_addr = '0;
        wr_data = '0;
        rst     = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs_a", {a_data, a_valid, a_last, a_busy, a_done, a_err}, 0);
        chk("reset_outputs_b", {b_data, b_valid, b_last, b_busy, b_done, b_err}, 0);
        rst = 1'b0;

        for (int i = 0; i < 32; i++) wr(1, i, 9'h141 + 9'(i));
        wr(4, 0, 9'h1FF);
        wr(1, 32, 9'h1EE);

        // Baseline stream with a stray start while busy.
        run_stream(1'b0, 16, 32, -1, -1, -1, 0, 9'h000, -1, 5);
        // Ready low while char 3 is presented.
        run_stream(1'b0, 16, 32, 9, 13, -1, 0, 9'h000, -1, -1);
        // Patch char 20 early in the stream, then in its own FETCH cycle.
        run_stream(1'b0, 16, 32, -1, -1, 10, 20, 9'h13F, -1, -1);
        wr(1, 20, 9'h155);
        run_stream(1'b0, 16, 32, -1, -1, 43, 20, 9'h13F, -1, -1);
        wr(1, 20, 9'h155);

        // Out-of-range page.
        @(posedge clk); #1;
        start = 1'b1;
        page  = 5'd4;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("err_pulse", a_err, 1);
        chk("err_busy", a_busy, 0);
        chk("err_valid", a_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk("err_clears", a_err, 0);
        chk("err_stays_idle", a_busy, 0);

        // Abort mid-stream, then confirm the RAM survived.
        run_stream(1'b0, 16, 32, -1, -1, -1, 0, 9'h000, 20, -1);
        run_stream(1'b0, 16, 32, -1, -1, -1, 0, 9'h000, -1, -1);

        // No line-2 insertion, 8-char page.
        run_stream(1'b1, 0, 8, -1, -1, -1, 0, 9'h000, -1, -1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
